// File: rtl/bit_ops_unit.sv
// Registered bit-manipulation helpers for LSU/LRQ bookkeeping: popcount,
// lowest-set-bit pick (one-hot + index) and one-hot OR-mux, one register stage.

module bit_ops_word_gate #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] gated
);
  assign gated = word & {DATA_WIDTH{sel}};
endmodule

module bit_ops_unit #(
  parameter int WIDTH      = 8,
  parameter int OH_WORDS   = 4,
  parameter int DATA_WIDTH = 32,
  localparam int CNT_W     = $clog2(WIDTH) + 1,
  localparam int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_valid,
  input  logic [WIDTH-1:0]               i_vec,
  input  logic [OH_WORDS-1:0]            i_oh,
  input  logic [OH_WORDS*DATA_WIDTH-1:0] i_data,
  output logic                           o_valid,
  output logic [CNT_W-1:0]               o_cnt,
  output logic [WIDTH-1:0]               o_lsb_oh,
  output logic [IDX_W-1:0]               o_lsb_idx,
  output logic                           o_lsb_found,
  output logic [DATA_WIDTH-1:0]          o_sel,
  output logic                           o_oh_err
);

  logic [CNT_W-1:0]      cnt_d;
  logic [WIDTH-1:0]      neg_vec;
  logic [WIDTH-1:0]      lsb_oh_d;
  logic [IDX_W-1:0]      lsb_idx_d;
  logic                  found_d;
  logic [DATA_WIDTH-1:0] sel_d;
  logic                  oh_err_d;
  logic                  oh_seen;

  logic [OH_WORDS-1:0][DATA_WIDTH-1:0] words;
  logic [OH_WORDS-1:0][DATA_WIDTH-1:0] gated;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++)
      cnt_d = cnt_d + CNT_W'(i_vec[i]);
  end

  // Two's-complement trick isolates the lowest set bit; zero stays zero.
  assign neg_vec  = ~i_vec + WIDTH'(1);
  assign lsb_oh_d = i_vec & neg_vec;
  assign found_d  = |i_vec;

  // lsb_oh_d is at most one-hot, so OR-encoding its bit positions is exact.
  always_comb begin
    lsb_idx_d = '0;
    for (int i = 0; i < WIDTH; i++)
      if (lsb_oh_d[i]) lsb_idx_d = lsb_idx_d | IDX_W'(i);
  end

  genvar w;
  generate
    for (w = 0; w < OH_WORDS; w++) begin : g_word
      assign words[w] = i_data[w*DATA_WIDTH +: DATA_WIDTH];
      bit_ops_word_gate #(.DATA_WIDTH(DATA_WIDTH)) u_gate (
        .sel   (i_oh[w]),
        .word  (words[w]),
        .gated (gated[w])
      );
    end
  endgenerate

  always_comb begin
    sel_d = '0;
    for (int i = 0; i < OH_WORDS; i++)
      sel_d = sel_d | gated[i];
  end

  // Error as soon as a second select bit shows up; no full count needed.
  always_comb begin
    oh_seen  = 1'b0;
    oh_err_d = 1'b0;
    for (int i = 0; i < OH_WORDS; i++) begin
      if (i_oh[i] && oh_seen) oh_err_d = 1'b1;
      if (i_oh[i])            oh_seen  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid     <= 1'b0;
      o_cnt       <= '0;
      o_lsb_oh    <= '0;
      o_lsb_idx   <= '0;
      o_lsb_found <= 1'b0;
      o_sel       <= '0;
      o_oh_err    <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_cnt       <= cnt_d;
        o_lsb_oh    <= lsb_oh_d;
        o_lsb_idx   <= lsb_idx_d;
        o_lsb_found <= found_d;
        o_sel       <= sel_d;
        o_oh_err    <= oh_err_d;
      end
    end
  end

endmodule

// File: tb/tb_bit_ops_unit.sv
// Scoreboard bench for bit_ops_unit: directed vectors push expected results,
// a negedge monitor pops and compares whenever o_valid is high.

module tb_bit_ops_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic [7:0]   i_vec;
  logic [3:0]   i_oh;
  logic [127:0] i_data;
  logic         o_valid;
  logic [3:0]   o_cnt;
  logic [7:0]   o_lsb_oh;
  logic [2:0]   o_lsb_idx;
  logic         o_lsb_found;
  logic [31:0]  o_sel;
  logic         o_oh_err;

  typedef struct {
    logic [3:0]  cnt;
    logic [7:0]  lsb_oh;
    logic [2:0]  idx;
    logic        found;
    logic [31:0] sel;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_ops_unit #(.WIDTH(8), .OH_WORDS(4), .DATA_WIDTH(32)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_valid     (i_valid),
    .i_vec       (i_vec),
    .i_oh        (i_oh),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .o_cnt       (o_cnt),
    .o_lsb_oh    (o_lsb_oh),
    .o_lsb_idx   (o_lsb_idx),
    .o_lsb_found (o_lsb_found),
    .o_sel       (o_sel),
    .o_oh_err    (o_oh_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_cnt"},   32'(o_cnt), 32'd0);
    chk({tag, "_lsboh"}, 32'(o_lsb_oh), 32'd0);
    chk({tag, "_idx"},   32'(o_lsb_idx), 32'd0);
    chk({tag, "_found"}, 32'(o_lsb_found), 32'd0);
    chk({tag, "_sel"},   o_sel, 32'd0);
    chk({tag, "_err"},   32'(o_oh_err), 32'd0);
  endtask

  task automatic issue(input logic [7:0] vec, input logic [3:0] oh, input logic [127:0] data,
                       input logic [3:0] cnt, input logic [7:0] loh, input logic [2:0] idx,
                       input logic found, input logic [31:0] sel, input logic err);
    exp_t e;
    @(negedge clk);
    i_valid = 1'b1;
    i_vec   = vec;
    i_oh    = oh;
    i_data  = data;
    e.cnt = cnt; e.lsb_oh = loh; e.idx = idx; e.found = found; e.sel = sel; e.err = err;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 1'b0;
    i_vec   = 8'hFF;
    i_oh    = 4'b1111;
    i_data  = '1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: o_valid=1 with empty scoreboard");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cnt",    32'(o_cnt), 32'(e.cnt));
        chk("lsb_oh", 32'(o_lsb_oh), 32'(e.lsb_oh));
        chk("idx",    32'(o_lsb_idx), 32'(e.idx));
        chk("found",  32'(o_lsb_found), 32'(e.found));
        chk("sel",    o_sel, e.sel);
        chk("oh_err", 32'(o_oh_err), 32'(e.err));
      end
    end
  end

  localparam logic [127:0] WORDS_A = {32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADF00D};
  localparam logic [127:0] WORDS_B = {32'hFFFF0000, 32'hFFFF0000, 32'h00000F00, 32'h000000F0};
  localparam logic [127:0] WORDS_C = {32'h00000008, 32'h00000004, 32'h00000002, 32'h00000001};

  initial begin
    int budget;
    rst = 1'b1; i_valid = 1'b0; i_vec = '0; i_oh = '0; i_data = '0;
    #1;
    chk_all_zero("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Outputs must stay zero until the first strobe even if inputs are busy.
    idle();
    idle();
    @(negedge clk);
    chk_all_zero("post_rst");

    issue(8'hB4, 4'b0000, '0,      4'd4, 8'h04, 3'd2, 1'b1, 32'h0, 1'b0);
    issue(8'h00, 4'b0000, '0,      4'd0, 8'h00, 3'd0, 1'b0, 32'h0, 1'b0);
    issue(8'hFF, 4'b0000, '0,      4'd8, 8'h01, 3'd0, 1'b1, 32'h0, 1'b0);
    issue(8'h80, 4'b0100, WORDS_A, 4'd1, 8'h80, 3'd7, 1'b1, 32'h12345678, 1'b0);
    issue(8'h06, 4'b0011, WORDS_B, 4'd2, 8'h02, 3'd1, 1'b1, 32'h00000FF0, 1'b1);
    issue(8'h01, 4'b0000, WORDS_A, 4'd1, 8'h01, 3'd0, 1'b1, 32'h0, 1'b0);
    issue(8'h50, 4'b1111, WORDS_C, 4'd2, 8'h10, 3'd4, 1'b1, 32'h0000000F, 1'b1);
    issue(8'h60, 4'b1000, WORDS_A, 4'd2, 8'h20, 3'd5, 1'b1, 32'hDEADBEEF, 1'b0);

    // Hold behaviour: results stay from the last strobe while i_valid=0.
    issue(8'hB4, 4'b0100, WORDS_A, 4'd4, 8'h04, 3'd2, 1'b1, 32'h12345678, 1'b0);
    idle();
    @(negedge clk);
    chk("hold_valid", 32'(o_valid), 32'd0);
    chk("hold_cnt",   32'(o_cnt), 32'd4);
    chk("hold_idx",   32'(o_lsb_idx), 32'd2);
    chk("hold_sel",   o_sel, 32'h12345678);

    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset between edges clears outputs immediately.
    issue(8'h0C, 4'b0010, WORDS_A, 4'd2, 8'h04, 3'd2, 1'b1, 32'hCAFEF00D, 1'b0);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Pending operand killed by reset before its edge produces nothing.
    issue(8'h03, 4'b0001, WORDS_A, 4'd2, 8'h01, 3'd0, 1'b1, 32'h0BADF00D, 1'b0);
    #2;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    i_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("discard");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
